// File: rtl/sr_debounce_pkg.sv
// Shared types and constants for the SR push-button debounce front end.
package sr_debounce_pkg;

    localparam int DEBOUNCE_DEFAULT = 4;

    // Channel order inside the top-level channel vector.
    localparam int CH_SET   = 0;
    localparam int CH_RESET = 1;

    // Which input dominates when both debounced levels are high.
    typedef enum logic {
        PRIO_RESET_WINS = 1'b0,
        PRIO_SET_WINS   = 1'b1
    } sr_prio_e;

    // Per-channel debounce state: settled, or counting a disagreement.
    typedef enum logic {
        CH_STABLE   = 1'b0,
        CH_CHANGING = 1'b1
    } ch_state_e;

    // Counter width for a given debounce length; never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        if (cycles <= 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: two-flop synchroniser, disagreement counter and the
// debounced stable level.
module debounce_ch
    import sr_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic          stable_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    ch_state_e     state_reg;
    ch_state_e     state_next;
    logic          differ;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce state register: FSM state, count and settled level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= CH_STABLE;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
        end
    end

    assign differ = (sync2_reg != stable_reg);

    // Next state: any agreeing cycle restarts the count; the level only flips
    // after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        case (state_reg)
            CH_STABLE: begin
                cnt_next = '0;
                if (differ) begin
                    state_next = CH_CHANGING;
                    cnt_next   = CW'(1);
                end
            end
            CH_CHANGING: begin
                if (!differ) begin
                    state_next = CH_STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = CH_STABLE;
                    cnt_next    = '0;
                    stable_next = ~stable_reg;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
        endcase
    end

    assign stable = stable_reg;

endmodule

// File: rtl/sr_debounce.sv
// Debounced, priority-resolved set/reset drive for an SR latch, with rising
// edge pulses and a registered SR state.
module sr_debounce
    import sr_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int RESET_WINS      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic reset_raw,
    output logic s,
    output logic r,
    output logic set_pulse,
    output logic reset_pulse,
    output logic q,
    output logic qbar
);

    localparam sr_prio_e PRIO = (RESET_WINS != 0) ? PRIO_RESET_WINS : PRIO_SET_WINS;

    logic [1:0] raw_vec;
    logic [1:0] stable_vec;
    logic       s_reg;
    logic       r_reg;
    logic       set_pulse_reg;
    logic       reset_pulse_reg;
    logic       q_reg;
    logic       s_next;
    logic       r_next;
    logic       q_next;

    assign raw_vec[CH_SET]   = set_raw;
    assign raw_vec[CH_RESET] = reset_raw;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw_vec[gi]),
                .stable(stable_vec[gi])
            );
        end
    endgenerate

    // Priority resolution: the losing channel is masked so s and r are never
    // high together; the SR state follows the resolved levels.
    always_comb begin
        s_next = 1'b0;
        r_next = 1'b0;
        if (PRIO == PRIO_RESET_WINS) begin
            s_next = stable_vec[CH_SET] & ~stable_vec[CH_RESET];
            r_next = stable_vec[CH_RESET];
        end else begin
            s_next = stable_vec[CH_SET];
            r_next = stable_vec[CH_RESET] & ~stable_vec[CH_SET];
        end
        q_next = q_reg;
        if (s_next) begin
            q_next = 1'b1;
        end else if (r_next) begin
            q_next = 1'b0;
        end
    end

    // Output registers: drive levels, one-cycle rising-edge pulses, SR state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg           <= 1'b0;
            r_reg           <= 1'b0;
            set_pulse_reg   <= 1'b0;
            reset_pulse_reg <= 1'b0;
            q_reg           <= 1'b0;
        end else begin
            s_reg           <= s_next;
            r_reg           <= r_next;
            set_pulse_reg   <= s_next & ~s_reg;
            reset_pulse_reg <= r_next & ~r_reg;
            q_reg           <= q_next;
        end
    end

    assign s           = s_reg;
    assign r           = r_reg;
    assign set_pulse   = set_pulse_reg;
    assign reset_pulse = reset_pulse_reg;
    assign q           = q_reg;
    assign qbar        = ~q_reg;

endmodule

// File: doc/sr_debounce.md
# sr_debounce

Synchronous front end for the NOR-based `rs_latch` in `basics`: conditions two raw push-button inputs (set, reset) into clean, glitch-free, mutually exclusive `s`/`r` drive levels. Each channel is synchronised, debounced and edge-detected. Simultaneous set and reset is resolved by priority, so the downstream latch never sees its forbidden r=s=1 input. A registered SR flip-flop state (`q`/`qbar`) is also provided for fully synchronous consumers.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronised input must differ from its stable level before the stable level flips; legal range 2..65535.
- `RESET_WINS`, 1: 1 = reset has priority when both stable levels are 1; 0 = set has priority.

- `clk`, in, 1: sole clock; all state is updated on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `set_raw`, in, 1: asynchronous, bouncy set button.
- `reset_raw`, in, 1: asynchronous, bouncy reset button.
- `s`, out, 1: debounced, priority-resolved set level; drives `rs_latch.s`.
- `r`, out, 1: debounced, priority-resolved reset level; drives `rs_latch.r`.
- `set_pulse`, out, 1: one-cycle pulse on each rising edge of `s`.
- `reset_pulse`, out, 1: one-cycle pulse on each rising edge of `r`.
- `q`, out, 1: registered SR state.
- `qbar`, out, 1: always `~q`, combinational.

## Operation
- **Synchroniser:** two flops per channel (`*_sync1`, `*_sync2`).
- **Debounce, per channel:**
  - Registers: `stable` and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
  - When `sync2 == stable`, `cnt` clears to 0.
  - When they differ and `cnt == DEBOUNCE_CYCLES-1`, `stable` flips and `cnt` clears.
  - When they differ otherwise, `cnt` increments.
  - Any single agreeing cycle restarts the count. `cnt` never wraps.
- **Per-channel FSM:** STABLE (`cnt==0`, sync agrees) ↔ CHANGING (counting).
  - STABLE→CHANGING when sync disagrees.
  - CHANGING→STABLE when sync agrees (level unchanged), or when the count completes (level flipped).
- **Priority (`RESET_WINS=1`):**
  - `s_next = set_stable & ~reset_stable`
  - `r_next = reset_stable`
  - `RESET_WINS=0` is the mirror image.
  - `s` and `r` are never 1 together in any cycle.
- **Edge detect:**
  - `set_pulse <= s_next & ~s`
  - `reset_pulse <= r_next & ~r`
  - When priority masks set, no `set_pulse` is emitted. When reset later releases while set is still held, `s` rises and `set_pulse` fires.
- **State register:** `q <= 1` if `s_next`, `0` if `r_next`, else hold.
- **Reset:** all sync flops, `stable`, `cnt`, `s`, `r`, `set_pulse`, `reset_pulse` and `q` go to 0, so `qbar` = 1.
  - Reset asserted mid-count discards the count.
  - Buttons held through reset release are re-debounced from 0. They are not lost.

## Timing
- **Latency:** a raw level change that meets setup at edge E0 appears on `stable` at edge E0+`DEBOUNCE_CYCLES`+1. It appears on `s`/`r`/pulses/`q` at E0+`DEBOUNCE_CYCLES`+2.
- **Pulse width:** pulses are exactly one cycle wide.
- **Glitch rejection:** raw glitches shorter than `DEBOUNCE_CYCLES` cycles (after synchronisation) never change any output.
- **Independent channels:** the channels do not interact until the priority stage. Both flipping on the same edge is resolved by priority in that same cycle.
- **`qbar`:** changes in the same cycle as `q`, with no extra delay.

## Structure
- **Package `sr_debounce_pkg`:** `DEBOUNCE_DEFAULT` constant, `sr_prio_e` (RESET_WINS / SET_WINS) and the counter-width function.
- **Sub-module `debounce_ch`:** synchroniser + counter + stable register, instantiated twice. The top holds the priority, edge-detect and `q` logic.
- **Top-level test bench:** instantiates `sr_debounce` driving `rs_latch`, and compares `rs_latch.q` with `sr_debounce.q` after settling.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Reset:** `rst=1` for 3 cycles with both raw inputs at 1, then `rst=0` →
  - During reset, all outputs are 0 and `qbar=1`.
  - After release, `r=1` 6 edges later and `s` stays 0 (`RESET_WINS`).
- **Clean set:** `set_raw` 0→1 held →
  - `s=1`, `set_pulse=1` for exactly one cycle and `q=1`, all 6 edges after the first sampling edge.
  - Latch `q=1` one gate delay later.
- **Bounce:** `set_raw` toggles 1,0,1,0 each cycle, then settles at 1 →
  - No output change during the bounce.
  - `s` rises 6 edges after the final settle, with a single `set_pulse`.
- **Conflict:** both raw inputs rise on the same cycle →
  - `r=1`, `s=0`, `q=0` and `reset_pulse` once.
  - Then `reset_raw` drops: `r` falls 6 edges later, `s` rises on that same edge with one `set_pulse`, and `q=1`.
- **Reset mid-count:** `set_raw`=1 for 3 cycles, `rst` pulsed for 1 cycle, `set_raw` held →
  - `s` rises 6 edges after `rst` deasserts, not earlier.
- **RESET_WINS=0 variant:** repeat the conflict scenario →
  - `s=1`, `r=0`, `q=1`.
  - `s` and `r` are never both 1 in any cycle (assertion active throughout).
